// File: rtl/tile_sequencer.sv
// rtl/tile_sequencer.sv - instruction sequencer driving the 8x8 MAC core for one weight tile
//
// Ports:
//   clk, reset        clock; synchronous active-low reset
//   start             one-cycle launch request, honoured only in IDLE
//   cfg_w_base        xmem address of weight vector 0
//   cfg_x_base        xmem address of activation vector 0
//   cfg_p_base        pmem address of the first psum
//   cfg_nij           number of activation vectors / psums
//   cfg_acc           value of inst[33] while executing
//   ofifo_valid       OFIFO head holds valid data
//   inst              34-bit core instruction (registered)
//   busy, done, err   status: not idle, completion pulse, sticky drain timeout
module tile_sequencer #(
    parameter int row      = 8,
    parameter int col      = 8,
    parameter int addr_bw  = 11,
    parameter int nij_bw   = 7,
    parameter int drain_to = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [addr_bw-1:0] cfg_w_base,
    input  logic [addr_bw-1:0] cfg_x_base,
    input  logic [addr_bw-1:0] cfg_p_base,
    input  logic [nij_bw-1:0]  cfg_nij,
    input  logic               cfg_acc,
    input  logic               ofifo_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [33:0] inst_idle = 34'h1_800C_0000;
    localparam int cnt_w  = ($clog2(row + col + 1) > nij_bw + 1) ? $clog2(row + col + 1) : nij_bw + 1;
    localparam int idle_w = $clog2(drain_to + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_W_XFER, S_W_LOAD, S_W_FLUSH, S_X_XFER, S_X_EXEC, S_X_TAIL, S_DRAIN, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [cnt_w-1:0]    cnt_q, cnt_d;
    logic [nij_bw-1:0]   written_q, written_d;
    logic [idle_w-1:0]   idle_q, idle_d;
    logic                err_d;
    logic [33:0]         inst_d;
    logic                pop;
    logic [addr_bw-1:0]  w_base_q, x_base_q, p_base_q, w_base_s;
    logic [nij_bw-1:0]   nij_q;
    logic                acc_q;

    // The first weight address is issued on the acceptance edge, before the
    // latched copy exists, so IDLE looks straight at the config input.
    assign w_base_s = (state_q == S_IDLE) ? cfg_w_base : w_base_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + cnt_w'(1);
        written_d = written_q;
        idle_d    = idle_q;
        err_d     = err;
        inst_d    = inst_idle;

        // Pops are decided from this cycle's ofifo_valid and appear on inst
        // the next cycle; written counts issued pops so none is repeated.
        pop = (state_q inside {S_X_EXEC, S_X_TAIL, S_DRAIN}) && ofifo_valid && (written_q < nij_q);

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    err_d     = 1'b0;
                    written_d = '0;
                    idle_d    = '0;
                    state_d   = (cfg_nij == '0) ? S_DONE : S_W_XFER;
                end
            end
            S_W_XFER: if (cnt_q == cnt_w'(col)) begin
                state_d = S_W_LOAD;
                cnt_d   = '0;
            end
            S_W_LOAD: if (cnt_q == cnt_w'(col - 1)) begin
                state_d = S_W_FLUSH;
                cnt_d   = '0;
            end
            S_W_FLUSH: if (cnt_q == cnt_w'(row + col - 1)) begin
                state_d = S_X_XFER;
                cnt_d   = '0;
            end
            S_X_XFER: if (cnt_q == cnt_w'(nij_q)) begin
                state_d = S_X_EXEC;
                cnt_d   = '0;
            end
            S_X_EXEC: if (cnt_q == cnt_w'(nij_q) - cnt_w'(1)) begin
                state_d = S_X_TAIL;
                cnt_d   = '0;
            end
            S_X_TAIL: if (cnt_q == cnt_w'(row + col - 1)) begin
                state_d = S_DRAIN;
                cnt_d   = '0;
            end
            S_DRAIN: begin
                cnt_d = '0;
                if (written_q == nij_q) begin
                    state_d = S_DONE;
                end else if (pop) begin
                    idle_d = '0;
                end else if (idle_q == idle_w'(drain_to - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    idle_d = idle_q + idle_w'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (pop) begin
            written_d = written_q + nij_bw'(1);
        end

        // Instruction for the cycle the FSM is about to enter. The extra
        // transfer cycle carries l0_wr alone to absorb the SRAM read latency.
        case (state_d)
            S_W_XFER: begin
                if (cnt_d < cnt_w'(col)) begin
                    inst_d[19]            = 1'b0;
                    inst_d[7 +: addr_bw]  = w_base_s + addr_bw'(cnt_d);
                end
                if (cnt_d != '0) inst_d[2] = 1'b1;
            end
            S_W_LOAD: begin
                inst_d[3] = 1'b1;
                inst_d[0] = 1'b1;
            end
            S_X_XFER: begin
                if (cnt_d < cnt_w'(nij_q)) begin
                    inst_d[19]            = 1'b0;
                    inst_d[7 +: addr_bw]  = x_base_q + addr_bw'(cnt_d);
                end
                if (cnt_d != '0) inst_d[2] = 1'b1;
            end
            S_X_EXEC: begin
                inst_d[33] = acc_q;
                inst_d[3]  = 1'b1;
                inst_d[1]  = 1'b1;
            end
            S_X_TAIL: begin
                inst_d[33] = acc_q;
                inst_d[1]  = 1'b1;
            end
            default: ;
        endcase

        if (pop) begin
            inst_d[6]             = 1'b1;
            inst_d[32]            = 1'b0;
            inst_d[31]            = 1'b0;
            inst_d[20 +: addr_bw] = p_base_q + addr_bw'(written_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            written_q <= '0;
            idle_q    <= '0;
            w_base_q  <= '0;
            x_base_q  <= '0;
            p_base_q  <= '0;
            nij_q     <= '0;
            acc_q     <= 1'b0;
            inst      <= inst_idle;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            written_q <= written_d;
            idle_q    <= idle_d;
            inst      <= inst_d;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
            err       <= err_d;
            if (state_q == S_IDLE && start) begin
                w_base_q <= cfg_w_base;
                x_base_q <= cfg_x_base;
                p_base_q <= cfg_p_base;
                nij_q    <= cfg_nij;
                acc_q    <= cfg_acc;
            end
        end
    end

endmodule

// File: doc/tile_sequencer.md
Name: tile_sequencer

Overview:
- FSM that drives the 34-bit `inst` bus of the 8x8 MAC core for one weight tile.
- Sequence:
  - Weights: xmem → L0 → array.
  - Activations: xmem → L0 → execute.
  - Drain: OFIFO → psum SRAM (pmem).
- Sits between the host/PYNQ wrapper register block and `core`. Software programs base addresses and vector count, then pulses `start`.

Parameters:
- row, 8, PE rows (L0 lanes)
- col, 8, PE columns; also the number of weight vectors per tile
- addr_bw, 11, SRAM address width
- nij_bw, 7, width of the activation-vector count (max 64, the OFIFO depth)
- drain_to, 255, idle cycles tolerated in DRAIN before error

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset (reset=0 resets on the rising clk edge)
- start  in  1  one-cycle launch request, sampled only in IDLE
- cfg_w_base  in  addr_bw  xmem address of weight vector 0
- cfg_x_base  in  addr_bw  xmem address of activation vector 0
- cfg_p_base  in  addr_bw  pmem address of first psum
- cfg_nij  in  nij_bw  number of activation vectors/psums
- cfg_acc  in  1  value driven on inst[33] during execute
- ofifo_valid  in  1  OFIFO head holds valid data (from core)
- inst  out  34  core instruction
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at completion
- err  out  1  drain timeout; sticky until next accepted start or reset

Behaviour:
- inst bit map:
  - acc[33], CEN_pmem[32], WEN_pmem[31], A_pmem[30:20]
  - CEN_xmem[19], WEN_xmem[18], A_xmem[17:7]
  - ofifo_rd[6], ififo_wr[5], ififo_rd[4], l0_rd[3], l0_wr[2], execute[1], load[0]
- Idle inst = 34'h1_800C_0000: both CENs=1, both WENs=1, all else 0.
- All outputs are registered.
  - Reset values: inst=idle, busy=0, done=0, err=0; state=IDLE; counters=0.
  - Reset mid-operation aborts and returns to IDLE; no partial completion is flagged.
- Config is latched on start acceptance (IDLE & start). start in any other state is ignored.
- cfg_nij==0: go straight to DONE with no inst activity.
- States, with cycle 1 = first cycle after acceptance:
  - W_XFER (col+1 cycles), counter k=0..col:
    - For k<col: CEN_xmem=0, WEN_xmem=1, A_xmem=w_base+k.
    - For k>=1: l0_wr=1, covering the 1-cycle SRAM read latency.
  - W_LOAD (col cycles): l0_rd=1, load=1.
  - W_FLUSH (row+col cycles): inst idle, while weights settle.
  - X_XFER (nij+1 cycles): same pattern as W_XFER, using x_base and nij.
  - X_EXEC (nij cycles): l0_rd=1, execute=1, acc=cfg_acc.
  - X_TAIL (row+col cycles): execute=1, acc=cfg_acc, l0_rd=0.
  - DRAIN: wait until written==nij.
  - DONE (1 cycle): done=1, then IDLE.
- Drain runs in X_EXEC, X_TAIL and DRAIN. In any cycle with ofifo_valid=1 and written<nij, assert together:
  - ofifo_rd=1, CEN_pmem=0, WEN_pmem=0
  - A_pmem=p_base+written
  - then written++
- Other pmem/xmem fields keep their idle values unless set by the current state.
- Drain timeout:
  - An idle counter resets on every pop and counts only in DRAIN.
  - Reaching drain_to sets err=1, pulses done and goes to IDLE.
- Address arithmetic is base+counter modulo 2^addr_bw (wrap, no carry out).
- ififo_wr/ififo_rd are always 0.

Test Plan:
- Reset: hold reset=0 for 2 cycles → inst=34'h1_800C_0000, busy=0, done=0, err=0. Release with start=0 → still idle.
- Weight phase (w_base=0x010):
  - Cycles 1–8: A_xmem=0x010..0x017 with CEN_xmem=0, WEN_xmem=1.
  - Cycles 2–9: l0_wr=1.
  - Cycles 10–17: l0_rd=load=1.
  - Cycles 18–33: idle inst.
- Exec/drain (nij=4, x_base=0x100, p_base=0x020, cfg_acc=1, ofifo_valid=1 from X_TAIL onward):
  - 4 pops writing A_pmem 0x020..0x023, inst[33]=1 throughout execute.
  - done pulses once, busy falls the same cycle done clears.
- Wrap: x_base=0x7FE, nij=4 → A_xmem sequence 0x7FE, 0x7FF, 0x000, 0x001.
- Timeout: nij=2, only one ofifo_valid pulse → err=1 and done after 255 DRAIN idle cycles. Next start clears err.
- Robustness:
  - start pulsed during X_EXEC is ignored; the sequence is unchanged.
  - reset=0 during X_EXEC → next cycle inst=idle, busy=0, no done.
  - nij=0 → done the cycle after acceptance with no memory strobes.
